// File: rtl/ps_request_arbiter.sv
// Round-robin arbiter sharing one PS request port between NUM_REQ requesters; responses are steered back in order via an ID queue.
// Optional build macro PS_ARB_STATS_EN adds saturating per-requester handshake counters on grant_count.
module ps_request_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            ps_valid,
    output logic                            ps_write,
    output logic [ADDR_WIDTH-1:0]           ps_addr,
    output logic [DATA_WIDTH-1:0]           ps_wdata,
    input  logic                            ps_ready,
    input  logic                            rsp_in_valid,
    input  logic [DATA_WIDTH-1:0]           rsp_in_rdata,
    input  logic                            rsp_in_wresp,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_wresp,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
`ifdef PS_ARB_STATS_EN
    output logic [NUM_REQ*32-1:0]           grant_count,
`endif
    output logic                            err_unexpected
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic                   ps_valid_q, ps_valid_d;
    logic                   ps_write_q, ps_write_d;
    logic [ADDR_WIDTH-1:0]  ps_addr_q, ps_addr_d;
    logic [DATA_WIDTH-1:0]  ps_wdata_q, ps_wdata_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_wresp_q, rsp_wresp_d;
    logic                   err_q, err_d;
    logic [ID_W-1:0]        id_mem_q [MAX_OUTSTANDING];

    logic                   grant_found_s;
    logic [ID_W-1:0]        grant_idx_s;
    logic                   can_grant_s;
    logic                   push_s;
    logic                   pop_s;

    // Round-robin search: first valid requester starting at rr_ptr.
    always_comb begin
        logic [ID_W:0] sum_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum_v >= (ID_W+1)'(NUM_REQ)) begin
                sum_v = sum_v - (ID_W+1)'(NUM_REQ);
            end else begin
                sum_v = sum_v;
            end
            if (!grant_found_s && req_valid[sum_v[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = sum_v[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // The full check uses the registered count so a same-cycle pop never admits a grant early.
    assign can_grant_s = (state_q == ARB) && grant_found_s && (count_q < CNT_W'(MAX_OUTSTANDING));
    assign push_s      = (state_q == HOLD) && ps_valid_q && ps_ready;
    assign pop_s       = rsp_in_valid && (count_q != '0);
    assign req_ready   = can_grant_s ? (NUM_REQ'(1) << grant_idx_s) : '0;

    // Next-state logic for the FSM, ID queue and response path.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        ps_valid_d  = ps_valid_q;
        ps_write_d  = ps_write_q;
        ps_addr_d   = ps_addr_q;
        ps_wdata_d  = ps_wdata_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_wresp_d = rsp_wresp_q;
        err_d       = err_q;

        case (state_q)
            ARB: begin
                if (can_grant_s) begin
                    state_d    = HOLD;
                    ps_valid_d = 1'b1;
                    ps_write_d = req_write[grant_idx_s];
                    ps_addr_d  = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                    ps_wdata_d = req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d = grant_idx_s;
                end else begin
                    state_d = ARB;
                end
            end
            HOLD: begin
                if (push_s) begin
                    state_d    = ARB;
                    ps_valid_d = 1'b0;
                    rr_ptr_d   = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + ID_W'(1);
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d    = ARB;
                ps_valid_d = 1'b0;
            end
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            rsp_valid_d = NUM_REQ'(1) << id_mem_q[rd_ptr_q];
            rsp_rdata_d = rsp_in_rdata;
            rsp_wresp_d = rsp_in_wresp;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rsp_in_valid && (count_q == '0)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            ps_valid_q  <= 1'b0;
            ps_write_q  <= 1'b0;
            ps_addr_q   <= '0;
            ps_wdata_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_wresp_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            ps_valid_q  <= ps_valid_d;
            ps_write_q  <= ps_write_d;
            ps_addr_q   <= ps_addr_d;
            ps_wdata_q  <= ps_wdata_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_wresp_q <= rsp_wresp_d;
            err_q       <= err_d;
        end
    end

    // ID queue storage; entries are only meaningful below count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            id_mem_q[wr_ptr_q] <= grant_id_q;
        end
    end

    assign ps_valid       = ps_valid_q;
    assign ps_write       = ps_write_q;
    assign ps_addr        = ps_addr_q;
    assign ps_wdata       = ps_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_wresp      = rsp_wresp_q;
    assign outstanding    = count_q;
    assign err_unexpected = err_q;

`ifdef PS_ARB_STATS_EN
    logic [31:0] gcnt_q [NUM_REQ];
    logic [31:0] gcnt_d [NUM_REQ];

    // Saturating per-requester handshake counters.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push_s && (grant_id_q == ID_W'(i)) && (gcnt_q[i] != 32'hFFFF_FFFF)) begin
                gcnt_d[i] = gcnt_q[i] + 32'd1;
            end else begin
                gcnt_d[i] = gcnt_q[i];
            end
            grant_count[i*32 +: 32] = gcnt_q[i];
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                gcnt_q[i] <= 32'd0;
            end else begin
                gcnt_q[i] <= gcnt_d[i];
            end
        end
    end
`endif

endmodule
